ugate_sweep_ctrl: RTL and testbench
===================================

Name: ugate_sweep_ctrl

Overview:
Wishbone-controlled vector sequencer for the combinational universal gate (27-in, 6-out).
- Applies a programmable range of input vectors to the gate, one per sweep step.
- Waits a programmable settle time after each vector, then samples the gate outputs.
- Folds each sample into a 32-bit MISR signature, with optional stop on a masked output match.
- Lets the management SoC characterise the gate without bit-banging the pads.

Parameters:
IN_W, 27, gate input width
OUT_W, 6, gate output width (OUT_W <= 8)
SETTLE_W, 8, settle counter width
ADDR_BASE, 32'h3000_0000, register block base address; decode on adr[31:5]

Ports:
wb_clk_i  in  1  sole clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data
gate_in_o  out  IN_W  registered vector driven to the gate
gate_out_i  in  OUT_W  gate result
busy_o  out  1  sweep in progress
irq_o  out  1  done interrupt (level)

Behaviour:
- Reset: every register, gate_in_o, wbs_ack_o, wbs_dat_o, busy_o, irq_o and SIGNATURE are 0; FSM is in IDLE.
- Wishbone transaction:
  - A transaction is accepted when stb & cyc & !ack & adr[31:5]==ADDR_BASE[31:5].
  - wbs_ack_o pulses high for exactly 1 cycle, on the cycle after acceptance.
  - A write takes effect on the same edge that raises ack; each byte lane is gated by wbs_sel_i.
  - wbs_dat_o is registered and valid with ack; it is 0 otherwise.
  - Non-matching addresses get no ack.
- Registers (offset adr[4:2]):
  - 0x00 CTRL: [0] START (write-1 pulse, reads 0), [1] ABORT (write-1 pulse, reads 0), [2] STOP_ON_MATCH, [3] IRQ_EN.
  - 0x04 VEC_START[IN_W-1:0].
  - 0x08 VEC_COUNT[IN_W-1:0].
  - 0x0C SETTLE[SETTLE_W-1:0].
  - 0x10 MATCH: [OUT_W-1:0] value, [8+OUT_W-1:8] mask.
  - 0x14 STATUS (RO): [0] busy, [1] done, [2] matched, [3] aborted.
  - 0x18 LAST_VEC (RO).
  - 0x1C SIGNATURE (RO).
- Config writes (0x04-0x10, CTRL[3:2]) while busy are acked but ignored.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE.
- IDLE + START:
  - Clear done, matched and aborted; set SIGNATURE=32'hFFFF_FFFF.
  - Load vec=VEC_START and remaining=VEC_COUNT.
  - If VEC_COUNT==0, set done and stay in IDLE; otherwise go to APPLY.
  - busy_o rises on the edge after the START write.
- APPLY (1 cycle): gate_in_o<=vec, LAST_VEC<=vec, settle_cnt<=SETTLE, go to SETTLE.
- SETTLE: if settle_cnt==0 go to CAPTURE, else decrement. SETTLE=0 still spends 1 cycle here.
- CAPTURE (1 cycle):
  - Signature update: sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ zero-extended gate_out_i.
  - hit = ((gate_out_i ^ value) & mask)==0.
  - If hit & STOP_ON_MATCH: set matched and done, go to IDLE.
  - Else if remaining==1: set done, go to IDLE.
  - Else remaining--, vec<=vec+1 modulo 2^IN_W (wraps to 0), go to APPLY.
- Per-vector cost is SETTLE+3 cycles.
- gate_in_o holds its last vector after the sweep ends.
- ABORT while busy:
  - Takes priority over the current state's action; go to IDLE next edge with aborted=1 and done=0.
  - SIGNATURE and LAST_VEC keep their partial values.
  - ABORT in IDLE is a no-op.
- START while busy is ignored. START and ABORT written together: ABORT wins.
- irq_o = done & IRQ_EN; it clears when the next START clears done.
- busy_o = (state != IDLE).
- Asserting reset mid-sweep returns everything to reset values immediately.

Decomposition:
- Shared package ugate_pkg: register offset constants, CTRL/STATUS bit indices, FSM state enum, MISR seed (32'hFFFF_FFFF) and tap positions.
- One sub-module, ugate_wb_regs: Wishbone decode, ack, byte-lane write and readback mux.
- The FSM and MISR live in the top module.

Test Plan:
Bench gate model: gate_out_i = gate_in_o[5:0].
1. Reset asserted mid-bus-idle -> all ports 0; reads return STATUS=0, SIGNATURE=0; each read ack is 1 cycle wide.
2. VEC_START=0, COUNT=1, SETTLE=0, START -> busy_o high for 3 cycles, then STATUS=0x2, SIGNATURE=0xFFFF_FFFE, LAST_VEC=0.
3. VEC_START=0x3E, COUNT=3, SETTLE=2, START -> gate_in_o steps 0x3E,0x3F,0x40 every 5 cycles; busy 15 cycles; SIGNATURE=0xFFFF_FF7E; LAST_VEC=0x40.
4. MATCH value=0x05 mask=0x3F, STOP_ON_MATCH=1, IRQ_EN=1, VEC_START=0, COUNT=100 -> STATUS=0x6, LAST_VEC=5, irq_o=1 until next START.
5. VEC_START=0x7FF_FFFF, COUNT=2 -> gate_in_o goes 0x7FF_FFFF then 0; LAST_VEC=0; done set.
6. COUNT=50, START, then START and VEC_START write during SETTLE, then ABORT, then reset mid-sweep:
   - The START and VEC_START writes are ignored.
   - ABORT -> STATUS=0x8 and busy_o drops on the next edge.
   - Reset mid-sweep -> all outputs return to 0.

Source files
------------

// File: rtl/ugate_pkg.sv
// Shared constants for the universal-gate sweep controller: register map,
// CTRL/STATUS bit positions, FSM encoding and the MISR definition.
package ugate_pkg;
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_VEC_START = 3'd1;
  localparam logic [2:0] REG_VEC_COUNT = 3'd2;
  localparam logic [2:0] REG_SETTLE    = 3'd3;
  localparam logic [2:0] REG_MATCH     = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam logic [2:0] REG_LAST_VEC  = 3'd6;
  localparam logic [2:0] REG_SIG       = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_SOM    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_MATCHED = 2;
  localparam int STAT_ABORTED = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_APPLY   = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;
  localparam int MISR_TAP0 = 31;
  localparam int MISR_TAP1 = 21;
  localparam int MISR_TAP2 = 1;
  localparam int MISR_TAP3 = 0;

  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] din);
    return {sig[30:0], sig[MISR_TAP0] ^ sig[MISR_TAP1] ^ sig[MISR_TAP2] ^ sig[MISR_TAP3]} ^ din;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] din,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ugate_sweep_ctrl_if.sv
// Wishbone slave bus bundle for the sweep controller register block.
interface ugate_sweep_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/ugate_wb_regs.sv
// Wishbone decode, single-cycle ack, byte-lane config writes and readback mux.
module ugate_wb_regs
  import ugate_pkg::*;
#(
  parameter int          IN_W      = 27,
  parameter int          OUT_W     = 6,
  parameter int          SETTLE_W  = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  ugate_sweep_ctrl_if.slave   wb,
  input  logic                busy,
  input  logic [3:0]          status,
  input  logic [IN_W-1:0]     last_vec,
  input  logic [31:0]         sig,
  output logic                start_p,
  output logic                abort_p,
  output logic                stop_on_match,
  output logic                irq_en,
  output logic [IN_W-1:0]     vec_start,
  output logic [IN_W-1:0]     vec_count,
  output logic [SETTLE_W-1:0] settle,
  output logic [OUT_W-1:0]    match_val,
  output logic [OUT_W-1:0]    match_mask
);
  logic        acc, wr, ack_q;
  logic [2:0]  idx;
  logic [31:0] rd_mux, wnew, dat_q;
  logic        unused_ok;

  assign idx = wb.wbs_adr_i[4:2];
  assign acc = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
               (wb.wbs_adr_i[31:5] == ADDR_BASE[31:5]);
  assign wr  = acc & wb.wbs_we_i;

  // Command bits are pulses seen by the FSM on the same edge that raises ack.
  assign start_p = wr & (idx == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_START];
  assign abort_p = wr & (idx == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[CTRL_ABORT];

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_CTRL:      begin rd_mux[CTRL_SOM] = stop_on_match; rd_mux[CTRL_IRQ_EN] = irq_en; end
      REG_VEC_START: rd_mux[IN_W-1:0] = vec_start;
      REG_VEC_COUNT: rd_mux[IN_W-1:0] = vec_count;
      REG_SETTLE:    rd_mux[SETTLE_W-1:0] = settle;
      REG_MATCH:     begin rd_mux[OUT_W-1:0] = match_val; rd_mux[8 +: OUT_W] = match_mask; end
      REG_STATUS:    rd_mux[3:0] = status;
      REG_LAST_VEC:  rd_mux[IN_W-1:0] = last_vec;
      default:       rd_mux = sig;
    endcase
  end

  // Merging onto the current readback keeps unselected byte lanes intact.
  assign wnew      = byte_merge(rd_mux, wb.wbs_dat_i, wb.wbs_sel_i);
  assign unused_ok = ^{wnew, wb.wbs_adr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q         <= 1'b0;
      dat_q         <= '0;
      stop_on_match <= 1'b0;
      irq_en        <= 1'b0;
      vec_start     <= '0;
      vec_count     <= '0;
      settle        <= '0;
      match_val     <= '0;
      match_mask    <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~wb.wbs_we_i) ? rd_mux : '0;
      if (wr & ~busy) begin
        case (idx)
          REG_CTRL:      begin stop_on_match <= wnew[CTRL_SOM]; irq_en <= wnew[CTRL_IRQ_EN]; end
          REG_VEC_START: vec_start <= wnew[IN_W-1:0];
          REG_VEC_COUNT: vec_count <= wnew[IN_W-1:0];
          REG_SETTLE:    settle <= wnew[SETTLE_W-1:0];
          REG_MATCH:     begin match_val <= wnew[OUT_W-1:0]; match_mask <= wnew[8 +: OUT_W]; end
          default: ;
        endcase
      end
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
endmodule

// File: rtl/ugate_sweep_ctrl.sv
// Sweep sequencer: applies a vector range to the universal gate, waits the
// settle time, and folds every captured output into a 32-bit MISR.
module ugate_sweep_ctrl
  import ugate_pkg::*;
#(
  parameter int          IN_W      = 27,
  parameter int          OUT_W     = 6,
  parameter int          SETTLE_W  = 8,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  ugate_sweep_ctrl_if.slave wb,
  output logic [IN_W-1:0]   gate_in_o,
  input  logic [OUT_W-1:0]  gate_out_i,
  output logic              busy_o,
  output logic              irq_o
);
  logic                start_p, abort_p, stop_on_match, irq_en;
  logic [IN_W-1:0]     vec_start, vec_count, vec, remaining, last_vec;
  logic [SETTLE_W-1:0] settle, settle_cnt;
  logic [OUT_W-1:0]    match_val, match_mask;
  logic [1:0]          state;
  logic [31:0]         sig, din32;
  logic                done, matched, aborted, hit;
  logic [3:0]          status;

  ugate_wb_regs #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_W(SETTLE_W), .ADDR_BASE(ADDR_BASE)) u_regs (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .wb(wb), .busy(busy_o), .status(status),
    .last_vec(last_vec), .sig(sig), .start_p(start_p), .abort_p(abort_p),
    .stop_on_match(stop_on_match), .irq_en(irq_en), .vec_start(vec_start),
    .vec_count(vec_count), .settle(settle), .match_val(match_val), .match_mask(match_mask)
  );

  always_comb begin
    din32 = '0;
    din32[OUT_W-1:0] = gate_out_i;
  end

  assign hit    = ((gate_out_i ^ match_val) & match_mask) == '0;
  assign busy_o = (state != S_IDLE);
  assign irq_o  = done & irq_en;
  assign status = {aborted, matched, done, busy_o};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      vec        <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
      gate_in_o  <= '0;
      last_vec   <= '0;
      sig        <= '0;
      done       <= 1'b0;
      matched    <= 1'b0;
      aborted    <= 1'b0;
    end else if (abort_p && busy_o) begin
      // Abort overrides the state action; signature and LAST_VEC stay partial.
      state   <= S_IDLE;
      aborted <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_p && !abort_p) begin
          done      <= (vec_count == '0);
          matched   <= 1'b0;
          aborted   <= 1'b0;
          sig       <= MISR_SEED;
          vec       <= vec_start;
          remaining <= vec_count;
          state     <= (vec_count == '0) ? S_IDLE : S_APPLY;
        end
        S_APPLY: begin
          gate_in_o  <= vec;
          last_vec   <= vec;
          settle_cnt <= settle;
          state      <= S_SETTLE;
        end
        S_SETTLE:
          if (settle_cnt == '0) state <= S_CAPTURE;
          else settle_cnt <= settle_cnt - SETTLE_W'(1);
        S_CAPTURE: begin
          sig <= misr_next(sig, din32);
          if (hit && stop_on_match) begin
            matched <= 1'b1;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else if (remaining == IN_W'(1)) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            remaining <= remaining - IN_W'(1);
            vec       <= vec + IN_W'(1);
            state     <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ugate_sweep_ctrl.sv
// Bench: directed and randomized sweeps checked every cycle against a
// schedule/signature model derived from the register-level behaviour.
module tb_ugate_sweep_ctrl;
  localparam int          IN_W  = 27;
  localparam int          OUT_W = 6;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [2:0]  A_CTRL = 3'd0, A_VS = 3'd1, A_VC = 3'd2, A_SET = 3'd3,
                          A_MATCH = 3'd4, A_STAT = 3'd5, A_LAST = 3'd6, A_SIG = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  gate_in;
  logic [OUT_W-1:0] gate_out;
  logic             busy, irq;

  ugate_sweep_ctrl_if wb_if();

  ugate_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_W(8), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(wb_if), .gate_in_o(gate_in),
    .gate_out_i(gate_out), .busy_o(busy), .irq_o(irq)
  );

  assign gate_out = gate_in[5:0];
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc_n = 0, ack_cyc = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Model of the sweep in flight.
  bit              trk = 1'b0, m_irqen = 1'b0;
  int              e_cyc = 0, m_per = 3, m_n = 1;
  logic [IN_W-1:0] m_v0 = '0, m_prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] vec_at(input int k);
    return m_v0 + IN_W'(k);
  endfunction

  function automatic logic [31:0] fold(input logic [IN_W-1:0] v0, input int n);
    logic [31:0]     s;
    logic [IN_W-1:0] v;
    s = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      v = v0 + IN_W'(k);
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {26'b0, v[5:0]};
    end
    return s;
  endfunction

  // Each vector occupies S+3 cycles: one apply, S+1 settle, one capture.
  always @(negedge clk) if (trk) begin
    int j, k, p;
    logic [IN_W-1:0] g;
    logic eb;
    j  = cyc_n - e_cyc;
    k  = j / m_per;
    p  = j % m_per;
    eb = (j < m_n * m_per);
    if (!eb)         g = vec_at(m_n - 1);
    else if (p == 0) g = (k == 0) ? m_prev : vec_at(k - 1);
    else             g = vec_at(k);
    chk("busy", {31'b0, busy}, {31'b0, eb});
    chk("gate_in", {5'b0, gate_in}, {5'b0, g});
    chk("irq", {31'b0, irq}, {31'b0, !eb && m_irqen});
  end

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd, output logic b_ack);
    int t;
    @(negedge clk);
    wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_we_i = we;
    wb_if.wbs_adr_i = adr;  wb_if.wbs_dat_i = d;    wb_if.wbs_sel_i = sel;
    t = 0;
    do begin @(negedge clk); t++; end while (wb_if.wbs_ack_o !== 1'b1 && t < 8);
    chk("ack_seen", {31'b0, wb_if.wbs_ack_o}, 32'd1);
    rd = wb_if.wbs_dat_o; b_ack = busy; ack_cyc = cyc_n;
    wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_we_i = 1'b0;
    @(negedge clk);
    chk("ack_width", {31'b0, wb_if.wbs_ack_o}, 32'd0);
  endtask

  task automatic wb_wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] r; logic b;
    wb_xfer(1'b1, BASE | {27'b0, idx, 2'b00}, d, sel, r, b);
  endtask

  task automatic wb_rd(input logic [2:0] idx, output logic [31:0] r);
    logic b;
    wb_xfer(1'b0, BASE | {27'b0, idx, 2'b00}, 32'h0, 4'hF, r, b);
  endtask

  task automatic arm_sweep(input logic [IN_W-1:0] v0, input int cnt, input int s, input bit som,
                           input bit ie, input logic [5:0] mv, input logic [5:0] mm);
    logic [IN_W-1:0] v;
    int n;
    wb_wr(A_VS, {5'b0, v0});
    wb_wr(A_VC, cnt);
    wb_wr(A_SET, s);
    wb_wr(A_MATCH, {18'b0, mm, 2'b0, mv});
    n = cnt;
    for (int k = 0; k < cnt; k++) begin
      v = v0 + IN_W'(k);
      if (som && ((v[5:0] ^ mv) & mm) == 6'd0) begin n = k + 1; break; end
    end
    m_v0 = v0; m_per = s + 3; m_n = n; m_irqen = ie;
    wb_wr(A_CTRL, {28'b0, ie, som, 2'b01});
    e_cyc = ack_cyc;
    trk = 1'b1;
  endtask

  task automatic finish_sweep(input bit exp_match, output logic [31:0] sig, output logic [31:0] last);
    logic [31:0] r;
    repeat (m_n * m_per + 2) @(negedge clk);
    trk = 1'b0;
    m_prev = vec_at(m_n - 1);
    wb_rd(A_STAT, r); chk("status", r, {29'b0, exp_match, 2'b10});
    wb_rd(A_LAST, last); chk("last_vec", last, {5'b0, vec_at(m_n - 1)});
    wb_rd(A_SIG, sig); chk("signature", sig, fold(m_v0, m_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, sg, lv;
    logic b;
    int ja, ncap, napp;
    wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_we_i = 1'b0;
    wb_if.wbs_sel_i = 4'h0; wb_if.wbs_dat_i = '0;   wb_if.wbs_adr_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gate_in", {5'b0, gate_in}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ack", {31'b0, wb_if.wbs_ack_o}, 32'd0);
    chk("rst_dat", wb_if.wbs_dat_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_rd(A_STAT, r); chk("rst_status", r, 32'd0);
    wb_rd(A_SIG, r);  chk("rst_sig", r, 32'd0);

    // Non-matching address: no ack at all.
    @(negedge clk);
    wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_adr_i = BASE + 32'h20;
    repeat (4) begin @(negedge clk); chk("no_ack_foreign", {31'b0, wb_if.wbs_ack_o}, 32'd0); end
    wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0;

    // Byte lanes.
    wb_wr(A_VS, 32'h0);
    wb_wr(A_VS, 32'hAABB_CCDD, 4'b0010);
    wb_wr(A_VS, 32'hAABB_CCDD, 4'b1000);
    wb_rd(A_VS, r); chk("byte_lanes", r, 32'h0200_CC00);

    // COUNT=0 finishes immediately without going busy.
    wb_wr(A_VC, 32'd0);
    wb_xfer(1'b1, BASE, 32'd1, 4'hF, r, b);
    chk("cnt0_busy", {31'b0, b}, 32'd0);
    wb_rd(A_STAT, r); chk("cnt0_status", r, 32'h2);

    arm_sweep(27'd0, 1, 0, 1'b0, 1'b0, 6'd0, 6'd0);
    finish_sweep(1'b0, sg, lv);
    chk("t2_sig_lit", sg, 32'hFFFF_FFFE);
    chk("t2_last_lit", lv, 32'd0);

    arm_sweep(27'h3E, 3, 2, 1'b0, 1'b0, 6'd0, 6'd0);
    finish_sweep(1'b0, sg, lv);
    chk("t3_sig_lit", sg, 32'hFFFF_FF7E);
    chk("t3_last_lit", lv, 32'h40);

    arm_sweep(27'd0, 100, 0, 1'b1, 1'b1, 6'h05, 6'h3F);
    finish_sweep(1'b1, sg, lv);
    chk("t4_last_lit", lv, 32'd5);
    wb_rd(A_STAT, r); chk("t4_status_lit", r, 32'h6);
    chk("t4_irq_hold", {31'b0, irq}, 32'd1);

    arm_sweep(27'h7FF_FFFF, 2, 1, 1'b0, 1'b0, 6'd0, 6'd0);
    finish_sweep(1'b0, sg, lv);
    chk("t5_last_lit", lv, 32'd0);

    for (int i = 0; i < 10; i++) begin
      logic [IN_W-1:0] v0;
      logic [5:0] mv, mm;
      int cnt, s;
      bit som, ie;
      v0  = ($urandom_range(0, 2) == 0) ? 27'h7FF_FFFF - IN_W'($urandom_range(0, 3))
                                         : IN_W'($urandom);
      cnt = $urandom_range(1, 6);
      s   = $urandom_range(0, 4);
      som = $urandom_range(0, 1) == 1;
      ie  = $urandom_range(0, 1) == 1;
      mv  = 6'($urandom);
      mm  = 6'($urandom) & 6'h07;
      arm_sweep(v0, cnt, s, som, ie, mv, mm);
      finish_sweep(m_n < cnt || (som && ((vec_at(cnt - 1) ^ {21'b0, mv}) & {21'b0, mm}) == '0),
                   sg, lv);
    end

    // Ignored START/config write mid-sweep, then abort.
    arm_sweep(27'h100, 50, 10, 1'b0, 1'b0, 6'd0, 6'd0);
    repeat (2) @(negedge clk);
    wb_wr(A_CTRL, 32'd1);
    wb_wr(A_VS, 32'h55);
    wb_rd(A_VS, r); chk("busy_cfg_ignored", r, 32'h100);
    trk = 1'b0;
    wb_xfer(1'b1, BASE, 32'd2, 4'hF, r, b);
    chk("abort_busy_drop", {31'b0, b}, 32'd0);
    ja   = ack_cyc - e_cyc;
    ncap = (ja - 1) / m_per;
    napp = (ja - 2) / m_per + 1;
    wb_rd(A_STAT, r); chk("abort_status", r, 32'h8);
    wb_rd(A_SIG, r);  chk("abort_sig", r, fold(m_v0, ncap));
    wb_rd(A_LAST, r); chk("abort_last", r, {5'b0, vec_at(napp - 1)});

    // Reset mid-sweep.
    wb_wr(A_CTRL, 32'd1);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gate_in", {5'b0, gate_in}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    chk("mid_rst_ack", {31'b0, wb_if.wbs_ack_o}, 32'd0);
    chk("mid_rst_dat", wb_if.wbs_dat_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_rd(A_STAT, r); chk("mid_rst_status", r, 32'd0);
    wb_rd(A_SIG, r);  chk("mid_rst_sig", r, 32'd0);
    wb_rd(A_LAST, r); chk("mid_rst_last", r, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
